// File: rtl/axi_lite_sram_ctrl_pkg.sv
// axi_sram_pkg: response encodings, controller FSM states and the word-index
// shift shared by the AXI4-Lite SRAM controller and its bench.
// Optional feature macro: AXI_SRAM_WSTRB_RMW_EN adds the RMW_READ state.
package axi_sram_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Byte address to SRAM word index.
    localparam int WORD_SHIFT = 2;

`ifdef AXI_SRAM_WSTRB_RMW_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_STROBE,
        ST_WR_WAIT,
        ST_BRESP,
        ST_RD_STROBE,
        ST_RRESP,
        ST_RMW_READ
    } state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_STROBE,
        ST_WR_WAIT,
        ST_BRESP,
        ST_RD_STROBE,
        ST_RRESP
    } state_e;
`endif

    // Direction of the most recent IDLE grant, used for round-robin arbitration.
    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_RD = 1'b1
    } grant_e;

endpackage

// File: rtl/axi_lite_sram_ctrl_if.sv
// AXI4-Lite bus bundle between an initiator and axi_lite_sram_ctrl.
// The slave modport is the controller's view, master is the initiator's view.
// Optional feature macro (controller side): AXI_SRAM_WSTRB_RMW_EN.
interface axi_lite_sram_ctrl_if #(
    parameter int ADDR_W = 32
) ();

    logic [ADDR_W-1:0] s_awaddr;
    logic              s_awvalid;
    logic              s_awready;

    logic [31:0]       s_wdata;
    logic [3:0]        s_wstrb;
    logic              s_wvalid;
    logic              s_wready;

    logic [1:0]        s_bresp;
    logic              s_bvalid;
    logic              s_bready;

    logic [ADDR_W-1:0] s_araddr;
    logic              s_arvalid;
    logic              s_arready;

    logic [31:0]       s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rvalid;
    logic              s_rready;

    modport slave (
        input  s_awaddr, s_awvalid,
        output s_awready,
        input  s_wdata, s_wstrb, s_wvalid,
        output s_wready,
        output s_bresp, s_bvalid,
        input  s_bready,
        input  s_araddr, s_arvalid,
        output s_arready,
        output s_rdata, s_rresp, s_rvalid,
        input  s_rready
    );

    modport master (
        output s_awaddr, s_awvalid,
        input  s_awready,
        output s_wdata, s_wstrb, s_wvalid,
        input  s_wready,
        input  s_bresp, s_bvalid,
        output s_bready,
        output s_araddr, s_arvalid,
        input  s_arready,
        input  s_rdata, s_rresp, s_rvalid,
        output s_rready
    );

endinterface

// File: rtl/axi_lite_sram_ctrl_wstrb_merge.sv
// axi_sram_wstrb_merge: byte-wise merge of a new word over an old word.
// Bytes whose strobe bit is set come from new_word_i, the rest from old_word_i.
// Only instantiated when AXI_SRAM_WSTRB_RMW_EN is defined.
module axi_sram_wstrb_merge (
    input  logic [31:0] old_word_i,
    input  logic [31:0] new_word_i,
    input  logic [3:0]  strb_i,
    output logic [31:0] merged_o
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            assign merged_o[gi*8 +: 8] = strb_i[gi] ? new_word_i[gi*8 +: 8]
                                                    : old_word_i[gi*8 +: 8];
        end
    endgenerate

endmodule

// File: rtl/axi_lite_sram_ctrl.sv
// axi_lite_sram_ctrl: AXI4-Lite slave in front of a synchronous-write,
// combinational-read SRAM macro. One transaction in flight at a time;
// round-robin arbitration between writes and reads when both are pending.
// Optional feature macro: AXI_SRAM_WSTRB_RMW_EN enables read-modify-write for
// partial write strobes (otherwise partial strobes get SLVERR).
module axi_lite_sram_ctrl
    import axi_sram_pkg::*;
#(
    parameter int MEM_DEPTH = 1024,
    parameter int ADDR_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    axi_lite_sram_ctrl_if.slave s_axi,
    output logic [31:0]         mem_address,
    output logic [31:0]         mem_w_data,
    output logic                mem_chip_select,
    output logic                mem_write_en,
    input  logic [31:0]         mem_r_data,
    input  logic                mem_resp
);

    localparam int IDX_W   = $clog2(MEM_DEPTH);
    localparam int DEC_LSB = IDX_W + WORD_SHIFT;

    // Any set bit at or above the SRAM byte span means the access misses the array.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return (addr >> DEC_LSB) == '0;
    endfunction

    state_e      state_q, state_d;
    grant_e      last_grant_q, last_grant_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  resp_q, resp_d;

    logic wr_pending, rd_pending;
    logic grant_wr, grant_rd;
    logic cs, we_n, bvalid, rvalid;

`ifdef AXI_SRAM_WSTRB_RMW_EN
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] merged_word;

    axi_sram_wstrb_merge u_merge (
        .old_word_i (mem_r_data),
        .new_word_i (wdata_q),
        .strb_i     (wstrb_q),
        .merged_o   (merged_word)
    );
`endif

    assign wr_pending = s_axi.s_awvalid & s_axi.s_wvalid;
    assign rd_pending = s_axi.s_arvalid;

    // Readies are gated by reset so nothing is handshaken that the registers cannot latch.
    assign grant_wr = (state_q == ST_IDLE) && !reset && wr_pending &&
                      (!rd_pending || (last_grant_q == GRANT_RD));
    assign grant_rd = (state_q == ST_IDLE) && !reset && rd_pending && !grant_wr;

    // Next-state, datapath capture and per-state bus/SRAM strobes.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        resp_d       = resp_q;
`ifdef AXI_SRAM_WSTRB_RMW_EN
        wstrb_d      = wstrb_q;
`endif
        cs           = 1'b0;
        we_n         = 1'b1;
        bvalid       = 1'b0;
        rvalid       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant_wr) begin
                    last_grant_d = GRANT_WR;
                    addr_d       = 32'(s_axi.s_awaddr >> WORD_SHIFT);
                    wdata_d      = s_axi.s_wdata;
                    if (!addr_in_range(s_axi.s_awaddr)) begin
                        resp_d  = RESP_DECERR;
                        state_d = ST_BRESP;
                    end else if (s_axi.s_wstrb == 4'h0) begin
                        resp_d  = RESP_OKAY;
                        state_d = ST_BRESP;
                    end else if (s_axi.s_wstrb == 4'hF) begin
                        resp_d  = RESP_OKAY;
                        state_d = ST_WR_STROBE;
                    end else begin
`ifdef AXI_SRAM_WSTRB_RMW_EN
                        wstrb_d = s_axi.s_wstrb;
                        resp_d  = RESP_OKAY;
                        state_d = ST_RMW_READ;
`else
                        resp_d  = RESP_SLVERR;
                        state_d = ST_BRESP;
`endif
                    end
                end else if (grant_rd) begin
                    last_grant_d = GRANT_RD;
                    addr_d       = 32'(s_axi.s_araddr >> WORD_SHIFT);
                    if (!addr_in_range(s_axi.s_araddr)) begin
                        resp_d  = RESP_DECERR;
                        rdata_d = '0;
                        state_d = ST_RRESP;
                    end else begin
                        resp_d  = RESP_OKAY;
                        state_d = ST_RD_STROBE;
                    end
                end
            end
`ifdef AXI_SRAM_WSTRB_RMW_EN
            ST_RMW_READ: begin
                cs      = 1'b1;
                wdata_d = merged_word;
                state_d = ST_WR_STROBE;
            end
`endif
            ST_WR_STROBE: begin
                cs      = 1'b1;
                we_n    = 1'b0;
                state_d = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (mem_resp) begin
                    state_d = ST_BRESP;
                end
            end
            ST_BRESP: begin
                bvalid = 1'b1;
                if (s_axi.s_bready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_STROBE: begin
                cs      = 1'b1;
                rdata_d = mem_r_data;
                state_d = ST_RRESP;
            end
            ST_RRESP: begin
                rvalid = 1'b1;
                if (s_axi.s_rready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and captured transaction; reset drops any in-flight transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_RD;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            resp_q       <= RESP_OKAY;
`ifdef AXI_SRAM_WSTRB_RMW_EN
            wstrb_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            resp_q       <= resp_d;
`ifdef AXI_SRAM_WSTRB_RMW_EN
            wstrb_q      <= wstrb_d;
`endif
        end
    end

    assign s_axi.s_awready = grant_wr;
    assign s_axi.s_wready  = grant_wr;
    assign s_axi.s_arready = grant_rd;
    assign s_axi.s_bvalid  = bvalid;
    assign s_axi.s_rvalid  = rvalid;
    assign s_axi.s_bresp   = resp_q;
    assign s_axi.s_rresp   = resp_q;
    assign s_axi.s_rdata   = rdata_q;

    assign mem_address     = addr_q;
    assign mem_w_data      = wdata_q;
    assign mem_chip_select = cs;
    assign mem_write_en    = we_n;

endmodule

// File: tb/tb_axi_lite_sram_ctrl.sv
// Bench for axi_lite_sram_ctrl: directed scenarios plus randomized traffic,
// checked by a scoreboard against a word-array reference model.
// Follows the DUT build: AXI_SRAM_WSTRB_RMW_EN selects the partial-strobe rules.
module tb_axi_lite_sram_ctrl;

    localparam int MEM_DEPTH = 1024;
    localparam int IDX_W     = 10;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    axi_lite_sram_ctrl_if #(.ADDR_W(32)) bus ();

    logic [31:0] mem_address, mem_w_data, mem_r_data;
    logic        mem_chip_select, mem_write_en, mem_resp;

    axi_lite_sram_ctrl #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .s_axi           (bus),
        .mem_address     (mem_address),
        .mem_w_data      (mem_w_data),
        .mem_chip_select (mem_chip_select),
        .mem_write_en    (mem_write_en),
        .mem_r_data      (mem_r_data),
        .mem_resp        (mem_resp)
    );

    // SRAM macro stand-in: synchronous write, combinational read, registered ack.
    logic [31:0] sram [MEM_DEPTH];
    bit          stall_resp = 0;
    always @(posedge clk)
        if (mem_chip_select && !mem_write_en) sram[mem_address[IDX_W-1:0]] <= mem_w_data;
    always @(posedge clk or posedge reset)
        if (reset) mem_resp <= 1'b0;
        else       mem_resp <= mem_chip_select && !mem_write_en && !stall_resp;
    assign mem_r_data = sram[mem_address[IDX_W-1:0]];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int busy_cnt = 0;
    int stall_b  = 0;
    int stall_r  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit is_rd; logic [1:0] resp; logic [31:0] data; int lat; int hs; } resp_t;
    typedef struct { bit is_wr; logic [31:0] idx; logic [31:0] data; } strb_t;
    resp_t resp_q[$];
    strb_t strb_q[$];

    logic [31:0] model_mem [MEM_DEPTH];
    bit          m_last_rd = 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference write: decides response, latency and expected SRAM strobes.
    function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                        input logic [3:0] strb,
                                        output logic [1:0] resp, output int lat);
        logic [31:0] idx;
        logic [31:0] merged;
        idx = addr >> 2;
        if (addr >= 32'(MEM_DEPTH * 4)) begin
            resp = DECERR; lat = 1;
        end else if (strb == 4'h0) begin
            resp = OKAY; lat = 1;
        end else if (strb == 4'hF) begin
            model_mem[idx[IDX_W-1:0]] = data;
            strb_q.push_back('{1'b1, idx, data});
            resp = OKAY; lat = 3;
        end else begin
`ifdef AXI_SRAM_WSTRB_RMW_EN
            merged = model_mem[idx[IDX_W-1:0]];
            for (int b = 0; b < 4; b++)
                if (strb[b]) merged[b*8 +: 8] = data[b*8 +: 8];
            strb_q.push_back('{1'b0, idx, 32'h0});
            strb_q.push_back('{1'b1, idx, merged});
            model_mem[idx[IDX_W-1:0]] = merged;
            resp = OKAY; lat = 4;
`else
            merged = 32'h0;
            resp = SLVERR; lat = 1;
`endif
        end
    endfunction

    function automatic void model_read(input logic [31:0] addr, output logic [1:0] resp,
                                       output logic [31:0] data, output int lat);
        logic [31:0] idx;
        idx = addr >> 2;
        if (addr >= 32'(MEM_DEPTH * 4)) begin
            resp = DECERR; data = 32'h0; lat = 1;
        end else begin
            strb_q.push_back('{1'b0, idx, 32'h0});
            resp = OKAY; data = model_mem[idx[IDX_W-1:0]]; lat = 2;
        end
    endfunction

    // Drive a write and/or read; checks arbitration each cycle, queues expectations on accept.
    task automatic run_txns(input bit do_wr, input logic [31:0] waddr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input bit do_rd, input logic [31:0] raddr);
        bit wr_pend, rd_pend, exp_wr, exp_rd;
        logic [1:0] r;
        logic [31:0] d;
        int l, guard;
        wr_pend = do_wr; rd_pend = do_rd; guard = 0;
        bus.s_awaddr = waddr; bus.s_wdata = wdata; bus.s_wstrb = wstrb; bus.s_araddr = raddr;
        while (1) begin
            bus.s_awvalid = wr_pend; bus.s_wvalid = wr_pend; bus.s_arvalid = rd_pend;
            #1;
            if (busy_cnt == 0) begin
                exp_wr = wr_pend && (!rd_pend || m_last_rd);
                exp_rd = rd_pend && !exp_wr;
                check("grant", 32'({bus.s_awready, bus.s_wready, bus.s_arready}),
                      32'({exp_wr, exp_wr, exp_rd}));
            end else begin
                check("accept_while_busy", 32'({bus.s_awready, bus.s_wready, bus.s_arready}), 32'h0);
            end
            if (wr_pend && bus.s_awready && bus.s_wready) begin
                model_write(waddr, wdata, wstrb, r, l);
                resp_q.push_back('{1'b0, r, 32'h0, l, cyc});
                busy_cnt++; wr_pend = 0; m_last_rd = 0;
            end else if (rd_pend && bus.s_arready) begin
                model_read(raddr, r, d, l);
                resp_q.push_back('{1'b1, r, d, l, cyc});
                busy_cnt++; rd_pend = 0; m_last_rd = 1;
            end
            @(negedge clk); #1;
            guard++;
            if (!(wr_pend || rd_pend)) break;
            if (guard > 200) begin
                n_checks++; n_fail++;
                $display("FAIL accept_timeout: got no ready required ready within 200 cycles");
                break;
            end
        end
        bus.s_awvalid = 0; bus.s_wvalid = 0; bus.s_arvalid = 0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (busy_cnt > 0 && g < 200) begin
            @(negedge clk); g++;
        end
        if (busy_cnt > 0) begin
            n_checks++; n_fail++;
            $display("FAIL resp_timeout: got %0d outstanding required 0", busy_cnt);
            busy_cnt = 0; resp_q.delete();
        end
        @(negedge clk); #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ctrl"}, 32'({bus.s_awready, bus.s_wready, bus.s_arready, bus.s_bvalid,
                                   bus.s_rvalid, mem_chip_select, mem_write_en}), 32'h1);
        check({tag, "_resp"}, 32'({bus.s_bresp, bus.s_rresp}), 32'h0);
        check({tag, "_rdata"}, bus.s_rdata, 32'h0);
        check({tag, "_maddr"}, mem_address, 32'h0);
        check({tag, "_mwdata"}, mem_w_data, 32'h0);
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 32'h1000 + (32'($urandom_range(0, 255)) << 2);
        return (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    // Response monitor: pops the scoreboard when B or R is presented, applies stalls.
    initial begin
        bit seen;
        int cnt, limit;
        bit is_rd;
        resp_t cur;
        logic [1:0] first_resp;
        logic [31:0] first_data;
        seen = 0; cnt = 0;
        cur = '{1'b0, 2'b00, 32'h0, 0, 0};
        forever begin
            @(negedge clk);
            if (reset) begin
                seen = 0;
            end else if (bus.s_bvalid || bus.s_rvalid) begin
                is_rd = bus.s_rvalid;
                if (!seen) begin
                    seen = 1; cnt = 0;
                    check("single_valid", 32'(bus.s_bvalid & bus.s_rvalid), 32'h0);
                    if (resp_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_resp: got valid (rd=%0d) required none", is_rd);
                        cur = '{is_rd, 2'b00, 32'h0, 0, cyc};
                    end else begin
                        cur = resp_q[0];
                        check("resp_channel", 32'(is_rd), 32'(cur.is_rd));
                        check("latency", 32'(cyc - cur.hs), 32'(cur.lat));
                        check("resp_code", 32'(is_rd ? bus.s_rresp : bus.s_bresp), 32'(cur.resp));
                        if (cur.is_rd && cur.resp == OKAY) check("rdata", bus.s_rdata, cur.data);
                    end
                    first_resp = is_rd ? bus.s_rresp : bus.s_bresp;
                    first_data = bus.s_rdata;
                end else begin
                    check("resp_stable", 32'(is_rd ? bus.s_rresp : bus.s_bresp), 32'(first_resp));
                    if (is_rd) check("rdata_stable", bus.s_rdata, first_data);
                end
                limit = is_rd ? stall_r : stall_b;
                if (cnt < limit) begin
                    cnt++;
                    if (is_rd) bus.s_rready = 0; else bus.s_bready = 0;
                end else begin
                    if (is_rd) bus.s_rready = 1; else bus.s_bready = 1;
                    @(posedge clk);
                    if (resp_q.size() > 0) void'(resp_q.pop_front());
                    if (busy_cnt > 0) busy_cnt--;
                    seen = 0;
                end
            end
        end
    end

    // SRAM port monitor: every strobe cycle must match the next expected access.
    initial begin
        strb_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (mem_chip_select) begin
                    if (strb_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_strobe: got cs at addr 0x%08h required no access", mem_address);
                    end else begin
                        e = strb_q.pop_front();
                        check("strobe_we", 32'(mem_write_en), 32'(!e.is_wr));
                        check("strobe_addr", mem_address, e.idx);
                        if (e.is_wr) check("strobe_wdata", mem_w_data, e.data);
                    end
                end else if (!mem_write_en) begin
                    n_checks++; n_fail++;
                    $display("FAIL idle_we: got write_en 0 required 1 outside strobe");
                end
            end
        end
    end

    initial begin
        int kind;
        logic [3:0] strb;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            sram[i] = 32'h0; model_mem[i] = 32'h0;
        end
        bus.s_awvalid = 0; bus.s_wvalid = 0; bus.s_arvalid = 0;
        bus.s_awaddr = 0; bus.s_wdata = 0; bus.s_wstrb = 0; bus.s_araddr = 0;
        bus.s_bready = 1; bus.s_rready = 1;

        repeat (3) @(negedge clk);
        check_reset_vals("reset_init");
        #1 reset = 0;

        // Basic write then readback.
        run_txns(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0); wait_idle();
        run_txns(0, 32'h0, 32'h0, 4'h0, 1, 32'h10); wait_idle();

        // Contended grants, twice.
        run_txns(1, 32'h20, 32'h01020304, 4'hF, 1, 32'h10); wait_idle();
        run_txns(1, 32'h24, 32'hA5A5A5A5, 4'hF, 1, 32'h20); wait_idle();

        // Out-of-range read and write.
        run_txns(0, 32'h0, 32'h0, 4'h0, 1, 32'h1000); wait_idle();
        run_txns(1, 32'h1000, 32'h12345678, 4'hF, 0, 32'h0); wait_idle();

        // Full then partial strobe, then readback.
        run_txns(1, 32'h8, 32'h11223344, 4'hF, 0, 32'h0); wait_idle();
        run_txns(1, 32'h8, 32'hAABBCCDD, 4'b0011, 0, 32'h0); wait_idle();
        run_txns(0, 32'h0, 32'h0, 4'h0, 1, 32'h8); wait_idle();

        // Zero strobe: OKAY, no access.
        run_txns(1, 32'hC, 32'hFFFFFFFF, 4'h0, 1, 32'hC); wait_idle();

        // Back-pressure on both response channels with the other request waiting.
        stall_b = 5; stall_r = 5;
        run_txns(1, 32'h30, 32'h0BADF00D, 4'hF, 1, 32'h24); wait_idle();
        stall_b = 0; stall_r = 0;

        // Reset while waiting for the SRAM acknowledge.
        stall_resp = 1;
        bus.s_awaddr = 32'h40; bus.s_wdata = 32'hCAFEF00D; bus.s_wstrb = 4'hF;
        bus.s_awvalid = 1; bus.s_wvalid = 1;
        #1;
        check("rst_case_accept", 32'({bus.s_awready, bus.s_wready}), 32'h3);
        begin
            logic [1:0] r; int l;
            model_write(32'h40, 32'hCAFEF00D, 4'hF, r, l);
        end
        @(negedge clk); #1;
        bus.s_awvalid = 0; bus.s_wvalid = 0;
        repeat (2) @(negedge clk);
        #2 reset = 1;
        #1 check_reset_vals("reset_mid");
        m_last_rd = 1;
        repeat (2) @(negedge clk);
        #1 reset = 0; stall_resp = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_bvalid_after_reset", 32'(bus.s_bvalid), 32'h0);
        end
        #1;
        run_txns(0, 32'h0, 32'h0, 4'h0, 1, 32'h40); wait_idle();

        // Randomized traffic.
        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 2);
            case ($urandom_range(0, 7))
                0:       strb = 4'h0;
                1, 2, 3, 4: strb = 4'hF;
                default: strb = 4'($urandom_range(1, 14));
            endcase
            stall_b = $urandom_range(0, 3);
            stall_r = $urandom_range(0, 3);
            run_txns(kind != 1, rand_addr(), $urandom, strb, kind != 0, rand_addr());
            wait_idle();
        end
        stall_b = 0; stall_r = 0;

        repeat (3) @(negedge clk);
        check("resp_queue_drained", 32'(resp_q.size()), 32'h0);
        check("strobe_queue_drained", 32'(strb_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
